// File: rtl/ram_dump_tx.sv
// ram_dump_tx: reads the 16-byte RAM and sends each byte LSB-first on a UART 8N1 line.
// Optional framing (sync byte 0x55 and a trailing checksum) is enabled by defining RAM_DUMP_FRAME_EN.
module ram_dump_tx #(
   parameter int CLKS_PER_BIT = 234,
   parameter int READ_WAIT    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       addr_override,
   output logic [3:0] addr_out,
   input  logic [7:0] ram_data,
   output logic       tx,
   output logic       busy,
   output logic       done
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SET_ADDR  = 3'd1;
   localparam logic [2:0] WAIT      = 3'd2;
   localparam logic [2:0] START_BIT = 3'd3;
   localparam logic [2:0] DATA_BITS = 3'd4;
   localparam logic [2:0] STOP_BIT  = 3'd5;
`ifdef RAM_DUMP_FRAME_EN
   localparam logic [2:0] SYNC      = 3'd6;
   localparam logic [2:0] CHECKSUM  = 3'd7;
`endif
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] WAIT_LAST = 16'(READ_WAIT - 1);

   logic [2:0]  state;
   logic [15:0] cnt;
   logic [2:0]  bit_n;
   logic [7:0]  shift;
   logic [3:0]  idx;
   logic        start_q;
`ifdef RAM_DUMP_FRAME_EN
   logic [7:0]  sum;
   logic        head;
   logic        tail;
`endif

   logic bit_end;
   assign bit_end       = cnt == BIT_LAST;
   assign busy          = state != IDLE;
   assign addr_override = busy;
   assign addr_out      = idx;
   assign tx            = state == START_BIT ? 1'b0 : state == DATA_BITS ? shift[0] : 1'b1;

   // Dump sequencer: address stepping, RAM sampling and bit-time counting share one counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_n   <= '0;
         shift   <= '0;
         idx     <= '0;
         start_q <= 1'b0;
         done    <= 1'b0;
`ifdef RAM_DUMP_FRAME_EN
         sum     <= '0;
         head    <= 1'b0;
         tail    <= 1'b0;
`endif
      end else begin
         start_q <= start;
         done    <= 1'b0;
         case (state)
            IDLE:
               if (start && !start_q)
`ifdef RAM_DUMP_FRAME_EN
                  state <= SYNC;
`else
                  state <= SET_ADDR;
`endif
            SET_ADDR: state <= WAIT;
            WAIT:
               if (cnt == WAIT_LAST) begin
                  cnt   <= '0;
                  shift <= ram_data;
`ifdef RAM_DUMP_FRAME_EN
                  sum   <= sum + ram_data;
`endif
                  state <= START_BIT;
               end else cnt <= cnt + 16'd1;
            START_BIT:
               if (bit_end) begin
                  cnt   <= '0;
                  state <= DATA_BITS;
               end else cnt <= cnt + 16'd1;
            DATA_BITS:
               if (bit_end) begin
                  cnt   <= '0;
                  shift <= shift >> 1;
                  bit_n <= bit_n + 3'd1;
                  if (bit_n == 3'd7) state <= STOP_BIT;
               end else cnt <= cnt + 16'd1;
            STOP_BIT:
               if (bit_end) begin
                  cnt <= '0;
`ifdef RAM_DUMP_FRAME_EN
                  if (head) begin
                     head  <= 1'b0;
                     state <= SET_ADDR;
                  end else if (idx != 4'd15) begin
                     idx   <= idx + 4'd1;
                     state <= SET_ADDR;
                  end else if (!tail) state <= CHECKSUM;
                  else begin
                     state <= IDLE;
                     idx   <= '0;
                     done  <= 1'b1;
                     tail  <= 1'b0;
                     sum   <= '0;
                  end
`else
                  if (idx != 4'd15) begin
                     idx   <= idx + 4'd1;
                     state <= SET_ADDR;
                  end else begin
                     state <= IDLE;
                     idx   <= '0;
                     done  <= 1'b1;
                  end
`endif
               end else cnt <= cnt + 16'd1;
`ifdef RAM_DUMP_FRAME_EN
            SYNC: begin
               shift <= 8'h55;
               head  <= 1'b1;
               state <= START_BIT;
            end
            CHECKSUM: begin
               shift <= -sum;
               tail  <= 1'b1;
               state <= START_BIT;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_dump_tx.sv
// tb_ram_dump_tx: compares ram_dump_tx against a per-cycle byte-schedule model and a UART decoder.
module tb_ram_dump_tx;
   localparam int C  = 4;
   localparam int RW = 2;
`ifdef RAM_DUMP_FRAME_EN
   localparam bit FRAME = 1'b1;
`else
   localparam bit FRAME = 1'b0;
`endif
   localparam int LIT_OFF = FRAME ? 1 + 10 * C : 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] ram_data;
   logic       addr_override, tx, busy, done;
   logic [3:0] addr_out;

   int checks = 0;
   int errors = 0;
   int k = 0;
   bit active = 1'b0;
   int mode = 0;
   logic [3:0] addr_d = '0;

   logic [7:0] bv[18];
   int bs[18], bp[18], ad[18];
   int nb, endk;

   int lk[12] = '{3, 4, 7, 8, 12, 16, 20, 24, 28, 32, 36, 40};
   bit lv[12] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

   logic [7:0] rxq[$];
   bit rx_en = 1'b1;

   ram_dump_tx #(.CLKS_PER_BIT(C), .READ_WAIT(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .addr_override(addr_override),
      .addr_out(addr_out), .ram_data(ram_data), .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [3:0] a);
      return {a, ~a};
   endfunction

   // RAM model; mode 2 lags the address by one cycle.
   always @(posedge clk) addr_d <= addr_out;
   always_comb ram_data = mode == 0 ? pat(addr_out) : mode == 1 ? 8'hA5 : mode == 2 ? pat(addr_d) : 8'h01;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got %0h want %0h", name, k, act, exp);
      end
   endtask

   task automatic add_byte(input logic [7:0] v, input int p, input int a, inout int pos);
      bv[nb] = v;
      bp[nb] = p;
      ad[nb] = a;
      bs[nb] = pos;
      pos += p + 10 * C;
      nb++;
   endtask

   task automatic build();
      int pos = 1;
      logic [7:0] s = '0;
      logic [7:0] v;
      nb = 0;
      if (FRAME) add_byte(8'h55, 1, 0, pos);
      for (int a = 0; a < 16; a++) begin
         v = mode == 1 ? 8'hA5 : mode == 3 ? 8'h01 : pat(4'(a));
         s += v;
         add_byte(v, 1 + RW, a, pos);
      end
      if (FRAME) add_byte(-s, 1, 15, pos);
      endk = pos;
   endtask

   function automatic void model(input int kk, output logic etx, output logic ebusy,
                                 output logic edone, output logic [3:0] ead);
      int j;
      logic [7:0] b;
      etx = 1'b1; ebusy = 1'b0; edone = kk == endk; ead = '0;
      for (int i = 0; i < nb; i++)
         if (kk >= bs[i] && kk < bs[i] + bp[i] + 10 * C) begin
            j = kk - bs[i];
            b = bv[i];
            ebusy = 1'b1;
            ead = 4'(ad[i]);
            etx = j < bp[i] ? 1'b1 : j < bp[i] + C ? 1'b0 : j < bp[i] + 9 * C ? b[(j - bp[i] - C) / C] : 1'b1;
         end
   endfunction

   // Per-cycle compare of every output against the model while a dump run is active.
   always @(posedge clk) begin
      logic etx, ebusy, edone;
      logic [3:0] ead;
      if (active) begin
         k++;
         #1;
         model(k, etx, ebusy, edone, ead);
         chk("tx", tx, etx);
         chk("busy", busy, ebusy);
         chk("done", done, edone);
         chk("addr_override", addr_override, ebusy);
         chk("addr_out", addr_out, ead);
      end
   end

   // UART receiver sampling mid-bit.
   initial forever begin
      logic [7:0] b;
      @(negedge tx);
      repeat (C / 2) @(posedge clk);
      #1;
      if (tx == 1'b0) begin
         for (int i = 0; i < 8; i++) begin
            repeat (C) @(posedge clk);
            #1;
            b[i] = tx;
         end
         repeat (C) @(posedge clk);
         #1;
         if (rx_en && tx == 1'b1) rxq.push_back(b);
      end
   end

   task automatic run_dump(input int m, input bit hold, input int rst_at);
      int rp;
      mode = m;
      build();
      rp = bs[nb / 2] + 5;
      rxq.delete();
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      k = 0;
      active = 1'b1;
      for (int c = 0; c < endk + 40; c++) begin
         @(negedge clk);
         if (!hold && k == 3) start = 1'b0;
         if (hold && k == rp) start = 1'b0;
         if (hold && k == rp + 3) start = 1'b1;
         if (m == 1)
            for (int i = 0; i < 12; i++)
               if (k == lk[i] + LIT_OFF) chk("lit_tx", tx, lv[i]);
         if (rst_at < 0 && k == 689 + 2 * LIT_OFF) chk("lit_done", done, 1);
         if (k == rst_at) begin
            chk("pre_rst_tx", tx, 0);
            active = 1'b0;
            rx_en = 1'b0;
            rst = 1'b1;
            #1;
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ovr", addr_override, 0);
            chk("rst_addr", addr_out, 0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (30) begin
               @(negedge clk);
               chk("post_rst_done", done, 0);
               chk("post_rst_busy", busy, 0);
               chk("post_rst_tx", tx, 1);
            end
            repeat (30) @(negedge clk);
            rxq.delete();
            rx_en = 1'b1;
            return;
         end
      end
      active = 1'b0;
      chk("rx_count", rxq.size(), nb);
      for (int i = 0; i < nb && i < rxq.size(); i++) chk("rx_byte", rxq[i], bv[i]);
`ifdef RAM_DUMP_FRAME_EN
      if (m == 3 && rxq.size() == 18) chk("lit_cksum", rxq[17], 8'hF0);
`endif
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ovr", addr_override, 0);
      chk("reset_addr", addr_out, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_tx", tx, 1);
      run_dump(0, 1'b0, -1);
      run_dump(1, 1'b0, -1);
      run_dump(2, 1'b0, -1);
      run_dump(0, 1'b0, 224 + LIT_OFF);
      run_dump(0, 1'b1, -1);
      run_dump(0, 1'b0, -1);
      run_dump(3, 1'b0, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_dump_tx.md
# ram_dump_tx

Serial read-back engine for the CPU's 16-byte RAM: the reader counterpart of the manual RAM programming path. On a start request it takes over the memory address register's manual input, steps the address from 0 to 15 and samples each RAM byte. Each byte is transmitted LSB-first on a UART 8N1 line, so a host can verify a program entered on the switches. It sits in the FPGA top level beside the programming switches, on the onboard system clock, not the CPU clock.

## Interface

Parameters:
- CLKS_PER_BIT, 234, system-clock cycles per UART bit (27 MHz / 115200); legal range 2..65535
- READ_WAIT, 2, cycles between address change and RAM data sample; legal range 1..15

Ports:
- clk  input  1  onboard system clock; all state changes on its rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  dump request, already synchronised, level; a rising edge starts a dump
- addr_override  output  1  high while the block owns the MAR manual address input
- addr_out  output  4  RAM address being read
- ram_data  input  8  RAM output byte at addr_out
- tx  output  1  UART line; idles high
- busy  output  1  high from dump start until the final stop bit completes
- done  output  1  one-cycle pulse when a dump completes

## Operation

- States: IDLE, SET_ADDR, WAIT, START_BIT, DATA_BITS, STOP_BIT. With RAM_DUMP_FRAME_EN defined, also SYNC and CHECKSUM.
- IDLE:
  - tx=1, busy=0, addr_override=0, addr_out=0.
  - A rising edge on start (start=1 with the registered previous start=0) moves to SET_ADDR, or to SYNC when framing is enabled.
  - busy and addr_override rise on the cycle after the edge.
- SET_ADDR: drive addr_out = current index, addr_override=1. Next state is WAIT.
- WAIT:
  - Count READ_WAIT cycles.
  - On the final count, latch ram_data into the shift register. Next state is START_BIT.
- START_BIT: tx=0 for CLKS_PER_BIT cycles.
- DATA_BITS: tx = shift[0] for CLKS_PER_BIT cycles, then shift right. Runs for 8 bits.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. At the end:
  - Index < 15: increment the index, go to SET_ADDR.
  - Index = 15, framing disabled: go to IDLE. Pulse done, drop busy and addr_override, and return addr_out to 0, all on the same cycle.
  - Index = 15, framing enabled: go to CHECKSUM.
  - The index is 4-bit; there is no wrap to 0 inside a dump.
- start is ignored while busy, whether it is held high or re-pulsed. A new dump needs start to fall and rise again after returning to IDLE.
- rst asserted at any time, including mid-bit:
  - Immediately returns to IDLE with tx=1, busy=0, done=0, addr_override=0, addr_out=0.
  - Clears the baud counter, bit counter, shift register, index and checksum.
  - The truncated UART frame is not completed.
- ram_data is only sampled at the WAIT terminal cycle; changes at other times have no effect.

## Timing

- Reset values: tx=1, busy=0, done=0, addr_override=0, addr_out=0.
- Start edge to start-bit falling edge: 1 + 1 + READ_WAIT cycles (edge detect, SET_ADDR, WAIT).
- Per byte: 1 + READ_WAIT + 10*CLKS_PER_BIT cycles.
- Full dump, framing disabled: 16*(1+READ_WAIT+10*CLKS_PER_BIT) + 1 cycles from the start edge to the done pulse.
- The baud counter reloads on each bit boundary, so each bit lasts exactly CLKS_PER_BIT cycles with no accumulated drift.
- done is high for exactly one cycle, coincident with busy falling.

## Configuration

- RAM_DUMP_FRAME_EN defined:
  - The dump is framed: a sync byte 0x55 is sent before address 0.
  - A checksum byte is sent after address 15. The checksum is the 8-bit two's-complement negation of the sum (mod 256) of the 16 data bytes, so the sum of all data bytes plus the checksum ≡ 0 mod 256.
  - SYNC and CHECKSUM use the same start/data/stop sequencing as data bytes, without the SET_ADDR/WAIT stages.
  - Total: 18 bytes.
- RAM_DUMP_FRAME_EN undefined:
  - Only the 16 raw bytes are sent.
  - The sync, checksum and accumulator logic is absent.

## Test plan

- Reset: assert rst mid-bit during byte 5 -> within the same cycle, tx=1, busy=0, addr_override=0, addr_out=0; no done pulse.
- Basic dump: CLKS_PER_BIT=4, READ_WAIT=2, framing off, RAM model returns byte = {addr, ~addr} (e.g. addr 3 -> 0x3C). Pulse start -> bench UART decoder receives 0x0F, 0x1E, ... 0xF0 in order. done pulses once, at cycle 16*(3+40)+1 = 689 after the edge.
- Bit timing: a single 0xA5 byte -> tx low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
- Start while busy: hold start high through the dump and re-pulse it at byte 8 -> exactly one 16-byte dump and one done pulse. A new dump begins only after start falls and rises again.
- Address/sample timing: RAM changes data one cycle after the address changes -> the latched byte equals the new-address data; addr_override stays high for the whole dump and low in IDLE.
- Framing (RAM_DUMP_FRAME_EN): all bytes 0x01 -> 0x55, sixteen 0x01, then 0xF0 (sum 0x10 plus checksum 0xF0 ≡ 0); done pulses after the 18th stop bit.
